// File: rtl/fpga_robots_game_beeper_pkg.sv
// Shared definitions for the attention beeper: FSM encoding, default timing
// constants and the triangle shaping used by the tone generator.
package fpga_robots_game_beeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int          DEF_QDEPTH       = 4;
  localparam int          DEF_SHORT_FRAMES = 15;
  localparam int          DEF_LONG_FRAMES  = 45;
  localparam int          DEF_GAP_FRAMES   = 3;
  localparam logic [15:0] DEF_SHORT_INC    = 16'd63;
  localparam logic [15:0] DEF_LONG_INC     = 16'd31;

  // Folding the upper half of the sawtooth back down gives a triangle.
  function automatic logic [14:0] tri_amp(input logic [15:0] phase);
    return phase[15] ? ~phase[14:0] : phase[14:0];
  endfunction

endpackage

// File: rtl/fpga_robots_game_beeper_fifo.sv
// 1-bit request queue; pushes are dropped when full even if a pop happens in
// the same cycle, pops on empty are ignored.
module fpga_robots_game_beeper_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fpga_robots_game_beeper.sv
// Attention beeper: queues short/long requests and plays each as a frame-timed
// triangle tone followed by a silent gap, with a 1-bit sigma-delta audio output.
module fpga_robots_game_beeper
  import fpga_robots_game_beeper_pkg::*;
#(
  parameter int          QDEPTH       = DEF_QDEPTH,
  parameter int          SHORT_FRAMES = DEF_SHORT_FRAMES,
  parameter int          LONG_FRAMES  = DEF_LONG_FRAMES,
  parameter int          GAP_FRAMES   = DEF_GAP_FRAMES,
  parameter logic [15:0] SHORT_INC    = DEF_SHORT_INC,
  parameter logic [15:0] LONG_INC     = DEF_LONG_INC
) (
  input  logic clk,
  input  logic rst,
  input  logic want_attention_short,
  input  logic want_attention_long,
  input  logic framepulse,
  input  logic tick,
  output logic attention,
  output logic audio,
  output logic busy,
  output logic overflow
);

  localparam logic [5:0] SHORT_F = 6'(SHORT_FRAMES);
  localparam logic [5:0] LONG_F  = 6'(LONG_FRAMES);
  localparam logic [5:0] GAP_F   = 6'(GAP_FRAMES);

  state_t      state;
  logic [5:0]  frame_cnt;
  logic [15:0] phase;
  logic [15:0] inc;
  logic [14:0] amp;
  logic [14:0] acc;
  logic        req;
  logic        pop;
  logic        fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        last_frame;

  // A simultaneous short+long collapses to one long entry.
  assign req = want_attention_short | want_attention_long;

  fpga_robots_game_beeper_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req),
    .din   (want_attention_long),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign last_frame = framepulse && (frame_cnt == 6'd1);

  // The next tone starts straight from IDLE, or back-to-back at the end of a gap.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_GAP) && last_frame));

  assign amp  = (state == ST_TONE) ? tri_amp(phase) : 15'd0;
  assign busy = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
      phase     <= '0;
      inc       <= '0;
      attention <= 1'b0;
    end else if (pop) begin
      // Loading takes priority; a framepulse in this cycle is not counted.
      state     <= ST_TONE;
      attention <= 1'b1;
      frame_cnt <= fifo_dout ? LONG_F : SHORT_F;
      inc       <= fifo_dout ? LONG_INC : SHORT_INC;
      phase     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          attention <= 1'b0;
        end
        ST_TONE: begin
          if (tick) phase <= phase + inc;
          if (last_frame) begin
            state     <= ST_GAP;
            attention <= 1'b0;
            frame_cnt <= GAP_F;
          end else if (framepulse) begin
            frame_cnt <= frame_cnt - 6'd1;
          end
        end
        ST_GAP: begin
          if (last_frame) begin
            state <= ST_IDLE;
          end else if (framepulse) begin
            frame_cnt <= frame_cnt - 6'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          attention <= 1'b0;
        end
      endcase
    end
  end

  // First-order sigma-delta: the carry out of the accumulator is the bitstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      audio    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      {audio, acc} <= {1'b0, acc} + {1'b0, amp};
      overflow     <= req && fifo_full;
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_beeper.sv
// Scoreboarded bench: a queue-based reference model predicts attention/overflow
// events plus per-cycle busy, audio and amplitude; a monitor pops and compares.
module tb_fpga_robots_game_beeper;

  localparam int QD     = 4;
  localparam int SHORTN = 15;
  localparam int LONGN  = 45;
  localparam int GAPN   = 3;
  localparam int SINC   = 63;
  localparam int LINC   = 31;
  localparam int FP_PER = 100;

  localparam int EV_RISE = 1;
  localparam int EV_FALL = 2;
  localparam int EV_OVF  = 3;

  typedef struct {
    int cyc;
    int what;
    int len;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ws = 1'b0;
  logic wl = 1'b0;
  logic fp = 1'b0;
  logic tick = 1'b0;
  logic attention, audio, busy, overflow;

  int n_checks = 0;
  int n_fail = 0;

  fpga_robots_game_beeper dut (
    .clk                  (clk),
    .rst                  (rst),
    .want_attention_short (ws),
    .want_attention_long  (wl),
    .framepulse           (fp),
    .tick                 (tick),
    .attention            (attention),
    .audio                (audio),
    .busy                 (busy),
    .overflow             (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int tri_model(input int p);
    return (p >= 32768) ? (65535 - p) : p;
  endfunction

  // ---------------- reference model ----------------
  ev_t sb[$];
  bit  mq[$];
  int  edge_n = 0;
  int  tone_left = 0, gap_left = 0, cur_len = 0;
  int  m_phase = 0, m_acc = 0, m_inc = 0;
  bit  m_attn = 0, m_ovf = 0, m_audio = 0, m_busy = 0;

  always @(posedge clk) begin
    bit prev_attn;
    bit full;
    bit start;
    bit k;
    int sum;
    edge_n++;
    prev_attn = m_attn;
    if (rst) begin
      mq.delete();
      tone_left = 0; gap_left = 0;
      m_phase = 0; m_acc = 0; m_inc = 0;
      m_attn = 0; m_ovf = 0; m_audio = 0;
    end else begin
      sum     = m_acc + (m_attn ? tri_model(m_phase) : 0);
      m_audio = (sum >= 32768);
      m_acc   = sum % 32768;
      if (m_attn && tick) m_phase = (m_phase + m_inc) % 65536;
      full  = (mq.size() == QD);
      start = 0;
      if (tone_left == 0 && gap_left == 0) begin
        start = (mq.size() > 0);
      end else if (tone_left > 0) begin
        if (fp) begin
          tone_left--;
          if (tone_left == 0) gap_left = GAPN;
        end
      end else if (fp) begin
        gap_left--;
        if (gap_left == 0) start = (mq.size() > 0);
      end
      if (start) begin
        k = mq.pop_front();
        tone_left = k ? LONGN : SHORTN;
        cur_len   = tone_left;
        m_inc     = k ? LINC : SINC;
        m_phase   = 0;
      end
      m_ovf = 0;
      if (ws || wl) begin
        if (full) m_ovf = 1;
        else mq.push_back(wl);
      end
      m_attn = (tone_left > 0);
    end
    m_busy = (tone_left > 0) || (gap_left > 0) || (mq.size() > 0);
    if (m_attn != prev_attn)
      sb.push_back('{edge_n, m_attn ? EV_RISE : EV_FALL, (m_attn || rst) ? -1 : cur_len});
    if (m_ovf) sb.push_back('{edge_n, EV_OVF, 0});
  end

  // ---------------- monitor ----------------
  logic obs_attn = 1'b0;
  int   fp_in_tone, ones_in_tone, cyc_in_tone, ticks_in_tone, max_amp;
  bit   all_tick;
  int   tones_done = 0, ovf_seen = 0;

  task automatic handle_event(input int what);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, expected none", what, edge_n);
      return;
    end
    e = sb.pop_front();
    chk("ev_kind", what, e.what);
    chk("ev_edge", edge_n, e.cyc);
    if (what == EV_FALL && e.len >= 0) begin
      tones_done++;
      chk("tone_frames", fp_in_tone, e.len);
      if (all_tick && cyc_in_tone > 0)
        chk("tone_duty_mid", ((ones_in_tone * 100 / cyc_in_tone) >= 35) &&
                             ((ones_in_tone * 100 / cyc_in_tone) <= 65), 1);
      if (ticks_in_tone >= 1100)
        chk("tone_peak", (max_amp >= 32767 - 63) && (max_amp <= 32767), 1);
    end
  endtask

  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("busy", busy, m_busy);
      chk("audio", audio, m_audio);
      chk("amp", dut.amp, m_attn ? tri_model(m_phase) : 0);
      if (attention !== obs_attn) begin
        if (attention === 1'b1) begin
          fp_in_tone = 0; ones_in_tone = 0; cyc_in_tone = 0;
          ticks_in_tone = 0; max_amp = 0; all_tick = 1;
        end
        handle_event(attention === 1'b1 ? EV_RISE : EV_FALL);
        obs_attn = attention;
      end
      if (overflow === 1'b1) begin
        ovf_seen++;
        handle_event(EV_OVF);
      end
      if (attention === 1'b1) begin
        cyc_in_tone++;
        if (fp) fp_in_tone++;
        if (audio) ones_in_tone++;
        if (tick) ticks_in_tone++;
        else all_tick = 0;
        if (int'(dut.amp) > max_amp) max_amp = int'(dut.amp);
      end
    end
  end

  // ---------------- background strobes ----------------
  bit tick_all = 1;
  int fp_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      fp_cnt = (fp_cnt + 1) % FP_PER;
      fp     = (fp_cnt == 0);
      tick   = tick_all ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic pulse(input logic s, input logic l);
    @(posedge clk); #1; ws = s; wl = l;
    @(posedge clk); #1; ws = 1'b0; wl = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    repeat (3) @(posedge clk);
    while ((m_busy || busy !== 1'b0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", nm, n);
    end
    repeat (5) @(posedge clk);
  endtask

  initial begin
    int t0, o0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_attention", attention, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_audio", audio, 0);

    // single short: N+2 latency
    @(posedge clk); #1 ws = 1'b1;
    @(posedge clk); #1 ws = 1'b0;
    @(negedge clk);
    chk("lat_n1_attention", attention, 0);
    chk("lat_n1_busy", busy, 1);
    @(negedge clk);
    chk("lat_n2_attention", attention, 1);
    wait_idle("single", 20000);

    // long then short, 5 cycles apart
    t0 = tones_done; o0 = ovf_seen;
    @(posedge clk); #1 wl = 1'b1;
    @(posedge clk); #1 wl = 1'b0;
    repeat (3) @(posedge clk);
    #1 ws = 1'b1;
    @(posedge clk); #1 ws = 1'b0;
    wait_idle("queue", 20000);
    chk("queue_tones", tones_done - t0, 2);
    chk("queue_ovf", ovf_seen - o0, 0);

    // six back-to-back shorts: one dropped
    t0 = tones_done; o0 = ovf_seen;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 ws = 1'b1;
    end
    @(posedge clk); #1 ws = 1'b0;
    wait_idle("overflow", 30000);
    chk("ovf_pulses", ovf_seen - o0, 1);
    chk("ovf_tones", tones_done - t0, 5);

    // short+long together -> a single long tone
    t0 = tones_done;
    pulse(1'b1, 1'b1);
    wait_idle("simul", 20000);
    chk("simul_tones", tones_done - t0, 1);

    // reset around frame 7 of a long tone with two queued
    t0 = tones_done;
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (6 * FP_PER + 20) @(posedge clk);
    @(negedge clk);
    chk("midrst_pre_attention", attention, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_attention", attention, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_audio", audio, 0);
    repeat (10 * FP_PER) @(posedge clk);
    @(negedge clk);
    chk("midrst_quiet_attention", attention, 0);
    chk("midrst_no_tones", tones_done - t0, 0);

    // randomized requests with random tick pattern
    tick_all = 0;
    for (int i = 0; i < 6; i++) begin
      int r;
      r = $urandom_range(0, 2);
      pulse(r != 1, r != 0);
      repeat ($urandom_range(1, 300)) @(posedge clk);
    end
    wait_idle("random", 40000);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
